// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state type and opcode decode helpers for alu_seq
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // True for every opcode the ALU implements
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND,
      OP_MULU, OP_DIVU, OP_REMU: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

  // True for the opcodes served by the iterative unit
  function automatic logic is_iter(input logic [3:0] op);
    is_iter = (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic             hi_nonzero
);

  // r_hi:r_lo is the 2*WIDTH accumulator. Multiply: r_lo starts as the
  // multiplier and is shifted out while the product fills in from the top.
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // Next accumulator value for one iteration of the selected algorithm
  always_comb begin
    w_add    = '0;
    w_shift  = '0;
    w_diff   = '0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op == OP_MULU) begin
      w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_hi_nxt = w_add[WIDTH:1];
      w_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
    end else begin
      // remainder < divisor, so a set bit WIDTH of the difference means borrow
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_b};
      if (!w_diff[WIDTH]) begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Outputs reflect the post-iteration value so the caller can register
  // the final answer on the same edge as the last iteration
  assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign lo         = (r_op == OP_REMU) ? w_hi_nxt : w_lo_nxt;
  assign hi_nonzero = |w_hi_nxt;

  // Load operands on start, then step once per cycle for WIDTH cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= OP_MULU;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_op   <= op;
      r_hi   <= '0;
      r_lo   <= a;
      r_b    <= b;
    end else if (r_busy) begin
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_cnt  <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshakes and held registered result
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             illegal
);

  alu_state_t       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;
  logic             r_illegal;

  logic [WIDTH-1:0] w_b_add;
  logic [WIDTH:0]   w_sum;
  logic             w_carry_msb;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;
  logic             w_illegal;
  logic             w_go_iter;
  logic             w_start;
  logic             w_done;
  logic [WIDTH-1:0] w_iter_lo;
  logic             w_iter_hi_nz;

  // Single-cycle result and flags, plus divide-by-zero shortcuts
  always_comb begin
    w_b_add     = (ALU_control == OP_SUB) ? ~src2 : src2;
    w_sum       = {1'b0, src1} + {1'b0, w_b_add} + {{WIDTH{1'b0}}, (ALU_control == OP_SUB)};
    w_carry_msb = src1[WIDTH-1] ^ w_b_add[WIDTH-1] ^ w_sum[WIDTH-1];
    w_slt       = $signed(src1) < $signed(src2);
    w_illegal   = !is_legal(ALU_control);
    w_res       = '0;
    w_cout      = 1'b0;
    w_ovf       = 1'b0;
    case (ALU_control)
      OP_AND:  w_res = src1 & src2;
      OP_OR:   w_res = src1 | src2;
      OP_NOR:  w_res = ~(src1 | src2);
      OP_NAND: w_res = ~(src1 & src2);
      OP_ADD, OP_SUB: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = w_carry_msb ^ w_sum[WIDTH];
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_DIVU: w_res = '1;
      OP_REMU: w_res = src1;
      default: w_res = '0;
    endcase
  end

  // A zero divisor is answered immediately instead of iterating
  assign w_go_iter = is_iter(ALU_control) && ((ALU_control == OP_MULU) || (src2 != '0));
  assign w_start   = (r_state == IDLE) && in_valid && w_go_iter;

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (w_start),
    .op         (ALU_control),
    .a          (src1),
    .b          (src2),
    .done       (w_done),
    .lo         (w_iter_lo),
    .hi_nonzero (w_iter_hi_nz)
  );

  // Control FSM: accept in IDLE, wait for the iterative unit, hold result in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= OP_AND;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op <= ALU_control;
            if (w_go_iter) begin
              r_state <= ITER;
            end else begin
              r_result  <= w_res;
              r_zero    <= (w_res == '0);
              r_cout    <= w_cout;
              r_ovf     <= w_ovf;
              r_illegal <= w_illegal;
              r_state   <= DONE;
            end
          end
        end
        ITER: begin
          if (w_done) begin
            r_result  <= w_iter_lo;
            r_zero    <= (w_iter_lo == '0);
            r_cout    <= 1'b0;
            r_ovf     <= (r_op == OP_MULU) && w_iter_hi_nz;
            r_illegal <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector table and corner sequences for alu_seq
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic [3:0]   ALU_control = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         overflow;
  logic         illegal;

  int n_cmp = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         o;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t v[20];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, scramble the inputs after accept, wait for out_valid; leaves DONE held
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic busy_ok);
    int n;
    @(negedge clk);
    in_valid = 1'b1; ALU_control = op; src1 = a; src2 = b; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; src1 = ~a; src2 = ~b; ALU_control = OP_ADD;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    logic bok;
    int   bad;
    int   seen;

    v[0]  = '{OP_SUB,  32'd5,          32'd7,          32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    v[1]  = '{OP_ADD,  32'h7FFFFFFF,   32'h00000001,   32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    v[2]  = '{OP_ADD,  32'hFFFFFFFF,   32'h00000001,   32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    v[3]  = '{OP_SLT,  32'h80000000,   32'h00000001,   32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    v[4]  = '{OP_NOR,  32'h00000000,   32'h00000000,   32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    v[5]  = '{OP_MULU, 32'h00010000,   32'h00010000,   32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 33};
    v[6]  = '{OP_MULU, 32'd6,          32'd7,          32'd42,       1'b0, 1'b0, 1'b0, 1'b0, 33};
    v[7]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,       1'b0, 1'b0, 1'b0, 1'b0, 33};
    v[8]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 33};
    v[9]  = '{OP_DIVU, 32'd9,          32'd0,          32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    v[10] = '{OP_REMU, 32'd9,          32'd0,          32'd9,        1'b0, 1'b0, 1'b0, 1'b0, 1};
    v[11] = '{4'b0011, 32'd12,         32'd34,         32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 1};
    v[12] = '{OP_AND,  32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    v[13] = '{OP_NAND, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    v[14] = '{OP_SLT,  32'h00000001,   32'h80000000,   32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    v[15] = '{OP_OR,   32'h0000000F,   32'h000000F0,   32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    v[16] = '{OP_SUB,  32'h80000000,   32'h00000001,   32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    v[17] = '{OP_MULU, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 33};
    v[18] = '{OP_DIVU, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 33};
    v[19] = '{OP_REMU, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 33};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {28'd0, zero, cout, overflow, illegal}, 32'd0);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 20; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, lat, bok);
      chk($sformatf("v%0d_latency", i),  lat,                      v[i].lat);
      chk($sformatf("v%0d_result", i),   result,                   v[i].res);
      chk($sformatf("v%0d_zero", i),     {31'd0, zero},            {31'd0, v[i].z});
      chk($sformatf("v%0d_cout", i),     {31'd0, cout},            {31'd0, v[i].c});
      chk($sformatf("v%0d_overflow", i), {31'd0, overflow},        {31'd0, v[i].o});
      chk($sformatf("v%0d_illegal", i),  {31'd0, illegal},         {31'd0, v[i].ill});
      chk($sformatf("v%0d_busy", i),     {31'd0, bok},             32'd1);
      release_out();
      chk($sformatf("v%0d_back_idle", i), {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Backpressure: hold DONE for 5 cycles with a competing request present
    do_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat, bok);
    in_valid = 1'b1; ALU_control = OP_MULU; src1 = 32'd3; src2 = 32'd3;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || in_ready || result !== 32'h80000000 || overflow !== 1'b1 ||
          zero !== 1'b0 || cout !== 1'b0 || illegal !== 1'b0) bad++;
    end
    chk("hold_stable", bad, 32'd0);
    in_valid = 1'b0;
    release_out();
    chk("hold_release", {30'd0, out_valid, in_ready}, 32'd1);

    // Reset at iteration 10 of a divide
    @(negedge clk);
    in_valid = 1'b1; ALU_control = OP_DIVU; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {30'd0, out_valid, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_result",    result,             32'd0);
    chk("midrst_flags",     {28'd0, zero, cout, overflow, illegal}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_late_valid", seen, 32'd0);
    do_op(OP_ADD, 32'd2, 32'd3, lat, bok);
    chk("post_rst_add_result",  result, 32'd5);
    chk("post_rst_add_latency", lat,    32'd1);
    release_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the datapath ALU.
- Executes the existing 4-bit ALU_control op set (AND/OR/ADD/SUB/NOR/NAND/SLT) in one registered cycle.
- Adds iterative unsigned multiply, divide and remainder.
- Valid/ready handshakes on both input and output; the pipeline controller can stall either side.
- Result and flags are registered and held until the consumer accepts them.

Parameters:
- WIDTH, 32: operand/result width in bits; minimum 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: operation request.
- in_ready, output, 1: block can accept a request.
- src1, input, WIDTH: operand A.
- src2, input, WIDTH: operand B.
- ALU_control, input, 4: opcode.
- out_valid, output, 1: result/flags valid.
- out_ready, input, 1: consumer accepts the result.
- result, output, WIDTH: registered result.
- zero, output, 1: result == 0.
- cout, output, 1: carry out of the MSB.
- overflow, output, 1: signed overflow (ADD/SUB); high-half nonzero (MULU).
- illegal, output, 1: unsupported opcode.

Behaviour:
Opcodes:
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (src1 + ~src2 + 1).
- 1100 NOR; 1101 NAND.
- 0111 SLT: signed compare, correct even when src1 - src2 overflows; result is 1 or 0.
- 1000 MULU: low WIDTH bits of the product.
- 1001 DIVU: quotient. 1010 REMU: remainder.
- Any other code: illegal.

Handshake:
- A request is accepted on a cycle where in_valid && in_ready.
- in_ready = (state == IDLE).
- An output is consumed on a cycle where out_valid && out_ready.

FSM states: IDLE, ITER, DONE.
- IDLE, accept of a single-cycle op, DIVU/REMU with src2 == 0, or an illegal op: compute and register result/flags, go to DONE. out_valid is 1 on cycle N+1.
- IDLE, accept of MULU/DIVU/REMU (divisor nonzero): latch operands, counter = 0, go to ITER.
- ITER: one bit per cycle.
  - MULU: shift-add into a 2*WIDTH accumulator.
  - DIVU/REMU: restoring division.
  - After WIDTH iterations, register outputs and go to DONE. out_valid is 1 on cycle N+WIDTH+1.
- DONE: out_valid = 1; result/flags held stable. On out_ready, go to IDLE. No new accept in that same cycle; minimum issue interval is 2 cycles.

Flags:
- zero: always computed from the registered result.
- cout and overflow: 0 for logic, SLT, DIVU, REMU.
- ADD/SUB: overflow = carry into MSB XOR carry out of MSB.
- MULU: cout = 0; overflow = (high half of product != 0).

Divide by zero: DIVU returns all ones; REMU returns src1.

Illegal opcode: result 0, zero 1, cout 0, overflow 0, illegal 1. illegal is 0 for all legal ops.

Reset (rst_n low at a clock edge, including mid-ITER or in DONE):
- State returns to IDLE; any in-flight operation is discarded with no out_valid.
- out_valid 0, in_ready 1 after reset, result 0, zero 0, cout 0, overflow 0, illegal 0.
- Counter and accumulators cleared.

Operand latching: src1, src2 and ALU_control are sampled only at accept. Later changes on the inputs have no effect.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND, OP_MULU, OP_DIVU, OP_REMU;
  - state enum alu_state_t {IDLE, ITER, DONE}.
- One sub-module, alu_iter_unit:
  - the shift-add / restoring-divide datapath with counter;
  - interface: start, op, a, b → done, lo, hi_nonzero.
- Single-cycle logic and the FSM stay in alu_seq.

Test Plan (WIDTH=32):
1. SUB src1=5, src2=7 → result 0xFFFFFFFE, cout 0, overflow 0, zero 0; out_valid exactly 1 cycle after accept.
2. ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow 1, cout 0. ADD 0xFFFFFFFF + 1 → 0, zero 1, cout 1. SLT 0x80000000 vs 0x00000001 → 1. NOR 0, 0 → 0xFFFFFFFF.
3. MULU 0x00010000 × 0x00010000 → result 0, zero 1, overflow 1. MULU 6 × 7 → 42, overflow 0. out_valid 33 cycles after accept; in_ready 0 throughout.
4. DIVU 100 / 7 → 14; REMU 100 / 7 → 2 (latency 33). DIVU 9 / 0 → 0xFFFFFFFF and REMU 9 / 0 → 9, each with latency 1.
5. Backpressure and illegal op: hold out_ready=0 for 5 cycles in DONE → result/flags stable, in_ready 0, a new in_valid is ignored. Opcode 0011 → illegal 1, result 0, zero 1.
6. Reset mid-ITER: assert rst_n=0 at iteration 10 of a DIVU → next cycle out_valid 0, in_ready 1, outputs 0. A fresh ADD 2+3 then returns 5.
